program_loader: RTL and testbench

Byte-stream writer for the core's instruction memory, the write side of the instruction fetch port.
- Receives a framed program image over a valid/ready byte interface.
- Assembles big-endian 32-bit words and writes them into consecutive instruction memory addresses.
- Holds the core in reset until the image is loaded and its checksum is verified.
- Sits between the board-level host link and the instruction_memory write port.

---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction memory loader: receives a framed byte stream (24-bit word count, big-endian
// payload words, XOR checksum), writes the words to imem and releases the core on success.
module program_loader #(
  parameter int ADDR_WIDTH = 18,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  error
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
  // byte_ready is a registered function of the state only; the sender holds
  // byte_in/byte_valid until the transfer happens.
  typedef enum logic [2:0] {HDR0, HDR1, HDR2, DATA, WRITE, CHECK, DONE, ERROR} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   MAX_N = (ADDR_WIDTH + 1)'(MAX_WORDS);

  state_t                state;
  logic [ADDR_WIDTH-1:0] n_words;
  logic [ADDR_WIDTH-1:0] index;
  logic [1:0]            byte_idx;
  logic [7:0]            csum;
  logic [23:0]           word;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] n_next;
  logic [ADDR_WIDTH-1:0] index_next;

  assign accept     = byte_valid && byte_ready;
  // Header bytes shift in from the bottom; only the low ADDR_WIDTH bits survive.
  assign n_next     = {n_words[ADDR_WIDTH-9:0], byte_in};
  assign index_next = index + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HDR0;
      n_words      <= '0;
      index        <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      word         <= '0;
      byte_ready   <= 1'b0;
      imem_address <= '0;
      imem_data    <= '0;
      imem_wren    <= 1'b0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_wren <= 1'b0;
      case (state)
        HDR0: begin
          byte_ready <= 1'b1;
          if (accept) begin
            n_words <= n_next;
            state   <= HDR1;
          end
        end
        HDR1: begin
          byte_ready <= 1'b1;
          if (accept) begin
            n_words <= n_next;
            state   <= HDR2;
          end
        end
        HDR2: begin
          byte_ready <= 1'b1;
          if (accept) begin
            n_words <= n_next;
            if ({1'b0, n_next} > MAX_N) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else if (n_next == '0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          byte_ready <= 1'b1;
          if (accept) begin
            csum     <= csum ^ byte_in;
            word     <= {word[15:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Outputs are registered here so the strobe appears exactly in WRITE.
              state        <= WRITE;
              byte_ready   <= 1'b0;
              imem_wren    <= 1'b1;
              imem_address <= BASE + index;
              imem_data    <= {word, byte_in};
            end
          end
        end
        WRITE: begin
          index      <= index_next;
          byte_ready <= 1'b1;
          state      <= (index_next == n_words) ? CHECK : DATA;
        end
        CHECK: begin
          byte_ready <= 1'b1;
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        DONE: begin
          byte_ready <= 1'b0;
          done       <= 1'b1;
          core_rst_n <= 1'b1;
        end
        ERROR: begin
          byte_ready <= 1'b0;
          error      <= 1'b1;
          core_rst_n <= 1'b0;
        end
        default: begin
          state      <= ERROR;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives framed byte streams and checks the imem
// write sequence through an expected-write queue plus final status flags.
module tb_program_loader;

  localparam int AW = 18;

  logic          clk;
  logic          rst_n;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;
  logic          imem_wren;
  logic          core_rst_n;
  logic          done;
  logic          error;

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(4096)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_address (imem_address),
    .imem_data    (imem_data),
    .imem_wren    (imem_wren),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .error        (error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc = -10;
  logic [AW+31:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (byte_valid && byte_ready) last_acc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every write strobe is compared with the head of exp_q
  always @(negedge clk) begin
    if (rst_n && imem_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {14'd0, imem_address, imem_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("write_addr_data", {14'd0, imem_address, imem_data}, {14'd0, exp_q.pop_front()});
      end
      check("write_latency", 64'(last_acc), 64'(cyc));
      check("ready_low_in_write", 64'(byte_ready), 64'd0);
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    int   waited;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    byte_valid = 1'b1;
    byte_in    = b;
    waited     = 0;
    r          = 1'b0;
    while (!r && waited < 100) begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    byte_valid = 1'b0;
    if (!r) check("byte_accept_timeout", 64'(waited), 64'd0);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_wren", 64'(imem_wren), 64'd0);
    check("rst_addr", 64'(imem_address), 64'd0);
    check("rst_data", 64'(imem_data), 64'd0);
    check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c);
    check({tag, "_done"}, 64'(done), 64'(d));
    check({tag, "_error"}, 64'(error), 64'(e));
    check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(c));
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  logic [7:0] frame[$];

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();

    // N=2 gap-free, checksum 0x38
    exp_q.push_back({18'd0, 32'h1234_5678});
    exp_q.push_back({18'd1, 32'hCAFE_BABE});
    frame = '{8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h38};
    send_frame(frame, 0);
    check_status("n2", 1'b1, 1'b0, 1'b1);
    drain("n2");

    // empty image, correct checksum
    do_reset();
    frame = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(frame, 0);
    check_status("n0_ok", 1'b1, 1'b0, 1'b1);
    drain("n0_ok");

    // empty image, wrong checksum
    do_reset();
    frame = '{8'h00, 8'h00, 8'h00, 8'h01};
    send_frame(frame, 0);
    check_status("n0_bad", 1'b0, 1'b1, 1'b0);
    drain("n0_bad");

    // N=1, wrong checksum (correct would be 0x22)
    do_reset();
    exp_q.push_back({18'd0, 32'hDEAD_BEEF});
    frame = '{8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_frame(frame, 0);
    check_status("n1_bad", 1'b0, 1'b1, 1'b0);
    drain("n1_bad");

    // oversize header: MAX_WORDS+1
    do_reset();
    frame = '{8'h00, 8'h10, 8'h01};
    send_frame(frame, 0);
    check_status("oversize", 1'b0, 1'b1, 1'b0);
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check_status("oversize_hold", 1'b0, 1'b1, 1'b0);
    drain("oversize");

    // N=2 with random gaps
    do_reset();
    exp_q.push_back({18'd0, 32'h1234_5678});
    exp_q.push_back({18'd1, 32'hCAFE_BABE});
    frame = '{8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h38};
    send_frame(frame, 5);
    check_status("gaps", 1'b1, 1'b0, 1'b1);
    drain("gaps");

    // reset after 2nd payload byte, then a fresh N=1 frame
    do_reset();
    frame = '{8'h00, 8'h00, 8'h02, 8'h12, 8'h34};
    send_frame(frame, 0);
    do_reset();
    drain("mid_reset");
    exp_q.push_back({18'd0, 32'h0102_0304});
    frame = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame(frame, 0);
    check_status("reload", 1'b1, 1'b0, 1'b1);
    drain("reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
